seg7_scan_driver: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.

---
 rtl/seg7_scan_driver.sv | 234 +++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed driver for an N-digit 7-segment display. It
//            keeps a frame-synchronous copy of a hex value and scans one
//            digit per refresh slot. Segment lines, the decimal point and the
//            digit selects are all registered and update on the same edge.
// Options  : LEADING_ZERO_SUPPRESS_EN - when defined, leading zero digits
//            (never digit 0) are blanked together with their decimal point.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int ACTIVE_HIGH_SEG = 0,
    parameter int ACTIVE_HIGH_AN  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic                      CA,
    output logic                      CB,
    output logic                      CC,
    output logic                      CD,
    output logic                      CE,
    output logic                      CF,
    output logic                      CG,
    output logic                      DP,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Drive level that lights a segment / selects a digit.
    localparam logic C_SEG_LIT = (ACTIVE_HIGH_SEG != 0);
    localparam logic C_AN_LIT  = (ACTIVE_HIGH_AN != 0);

    // Idle (unlit / unselected) levels used in reset and for blanked slots.
    localparam logic [6:0]            C_SEG_OFF = C_SEG_LIT ? 7'h00 : 7'h7F;
    localparam logic                  C_DP_OFF  = ~C_SEG_LIT;
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF  = C_AN_LIT ? '0 : '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    frame_tick_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_supp;

    // Output-stage intermediates
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_dp_req;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_seg_mask;
    logic                    w_dp_mask;

    // Active-low CA..CG pattern per hex nibble, returned as a lit mask.
    function automatic logic [6:0] f_seg_lit(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0:    p = 7'b0000001;
            4'h1:    p = 7'b1001111;
            4'h2:    p = 7'b0010010;
            4'h3:    p = 7'b0000110;
            4'h4:    p = 7'b1001100;
            4'h5:    p = 7'b0100100;
            4'h6:    p = 7'b0100000;
            4'h7:    p = 7'b0001111;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0000100;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b1100000;
            4'hC:    p = 7'b0110001;
            4'hD:    p = 7'b1000010;
            4'hE:    p = 7'b0110000;
            default: p = 7'b0111000;
        endcase
        return ~p;
    endfunction

    // ------------------------------------------------------------------
    // Refresh prescaler and scan index
    // ------------------------------------------------------------------
    assign w_tick = (cnt_q == C_CNT_MAX);
    assign w_wrap = w_tick && (idx_q == C_IDX_MAX);

    // Next prescaler count and scan index; index moves only on a tick.
    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Value capture: loads collect in pending and are promoted to the
    // displayed copy only at a frame boundary, so a frame is never torn.
    // A load on the boundary cycle itself goes straight to disp.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (w_wrap) begin
            if (load) begin
                disp_d     = value;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                disp_d     = pending_q;
                pend_vld_d = 1'b0;
            end
        end else if (load) begin
            pending_d  = value;
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask (digit 0 is never suppressed)
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_SUPPRESS_EN
    // Walk from the most significant digit down while nibbles stay zero.
    always_comb begin
        logic run;
        run    = 1'b1;
        w_supp = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run       = run && (disp_q[4*k +: 4] == 4'h0);
            w_supp[k] = (k != 0) && run;
        end
    end
`else
    assign w_supp = '0;
`endif

    // ------------------------------------------------------------------
    // Output stage: pick the digit under idx and form next pin levels.
    // ------------------------------------------------------------------
    // Select nibble/controls for the current digit and apply blanking.
    always_comb begin
        w_nib    = 4'h0;
        w_blank  = 1'b0;
        w_dp_req = 1'b0;
        w_sel    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_nib    = disp_q[4*k +: 4];
                w_blank  = blank[k] | w_supp[k];
                w_dp_req = dp_in[k];
                w_sel[k] = 1'b1;
            end
        end
        if (w_blank) begin
            w_seg_mask = 7'h00;
            w_dp_mask  = 1'b0;
            w_sel      = '0;
        end else begin
            w_seg_mask = f_seg_lit(w_nib);
            w_dp_mask  = w_dp_req;
        end
        seg_d = C_SEG_LIT ? w_seg_mask : ~w_seg_mask;
        dp_d  = C_SEG_LIT ? w_dp_mask  : ~w_dp_mask;
        an_d  = C_AN_LIT  ? w_sel      : ~w_sel;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Scan timing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= w_wrap;
        end
    end

    // Pending and displayed value copies; reset discards any pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
        end
    end

    // Pin registers: segments, DP and selects all change on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= C_SEG_OFF;
            dp_q  <= C_DP_OFF;
            an_q  <= C_AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots).
//            Expected display slots are queued by the stimulus; a monitor
//            pops one entry each time the pins change and also checks slot
//            length and frame_tick spacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;

    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0111000;
    localparam logic [6:0] SOFF = 7'b1111111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         dur;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = 16'h0;
    logic          load = 1'b0;
    logic [ND-1:0] blank = '0;
    logic [ND-1:0] dp_in = '0;
    logic          CA, CB, CC, CD, CE, CF, CG, DP;
    logic [ND-1:0] an;
    logic          frame_tick;

    logic          hCA, hCB, hCC, hCD, hCE, hCF, hCG, hDP;
    logic [ND-1:0] h_an;
    logic          h_ft;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_HIGH_SEG(0), .ACTIVE_HIGH_AN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank(blank),
        .dp_in(dp_in), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF),
        .CG(CG), .DP(DP), .an(an), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_HIGH_SEG(1), .ACTIVE_HIGH_AN(1)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .value(16'h0000), .load(1'b0), .blank(4'b0000),
        .dp_in(4'b0000), .CA(hCA), .CB(hCB), .CC(hCC), .CD(hCD), .CE(hCE), .CF(hCF),
        .CG(hCG), .DP(hDP), .an(h_an), .frame_tick(h_ft)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int dur);
        exp_t e;
        e.an = a; e.seg = s; e.dp = d; e.dur = dur;
        sb_q.push_back(e);
    endtask

    task automatic push_zero_frame();
`ifdef LEADING_ZERO_SUPPRESS_EN
        push(4'b1110, S0, 1'b1, 4);
        push(4'b1111, SOFF, 1'b1, 12);
`else
        push(4'b1110, S0, 1'b1, 4);
        push(4'b1101, S0, 1'b1, 4);
        push(4'b1011, S0, 1'b1, 4);
        push(4'b0111, S0, 1'b1, 4);
`endif
    endtask

    task automatic wait_ft();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_tick_timeout: got no pulse, expected one within 64 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) done = 1'b1;
        end
        mon_en = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Monitor: one scoreboard entry per pin change, plus timing checks.
    logic [11:0] prev_out;
    logic [11:0] cur_out;
    bit          have_cur = 1'b0;
    int          cur_start;
    int          cur_dur;
    bit          ft_valid = 1'b0;
    int          ft_last;

    always @(negedge clk) begin
        exp_t e;
        cur_out = {an, CA, CB, CC, CD, CE, CF, CG, DP};
        if (!mon_en) begin
            prev_out = cur_out;
            have_cur = 1'b0;
        end else if (cur_out != prev_out) begin
            if (have_cur && cur_dur != 0)
                check("slot_length", cyc - cur_start, cur_dur);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_change: got an=%b seg=%b, expected no change",
                         an, {CA, CB, CC, CD, CE, CF, CG});
                have_cur = 1'b0;
            end else begin
                e = sb_q.pop_front();
                check("slot_an",  {28'h0, an}, {28'h0, e.an});
                check("slot_seg", {25'h0, CA, CB, CC, CD, CE, CF, CG}, {25'h0, e.seg});
                check("slot_dp",  {31'h0, DP}, {31'h0, e.dp});
                cur_dur   = e.dur;
                cur_start = cyc;
                have_cur  = 1'b1;
            end
            prev_out = cur_out;
        end
        if (!rst_n) begin
            ft_valid = 1'b0;
        end else if (frame_tick) begin
            if (ft_valid) check("frame_tick_period", cyc - ft_last, 16);
            ft_last  = cyc;
            ft_valid = 1'b1;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg",   {25'h0, CA, CB, CC, CD, CE, CF, CG}, {25'h0, SOFF});
        check("rst_dp",    {31'h0, DP}, 32'h1);
        check("rst_an",    {28'h0, an}, 32'hF);
        check("rst_ft",    {31'h0, frame_tick}, 32'h0);
        check("rst_hi_an", {28'h0, h_an}, 32'h0);
        check("rst_hi_seg", {25'h0, hCA, hCB, hCC, hCD, hCE, hCF, hCG}, 32'h0);

        // Frames 0..5 of the main sequence.
        push_zero_frame();
        push(4'b1110, SF, 1'b1, 4);
        push(4'b1101, SA, 1'b1, 4);
        push(4'b1011, S2, 1'b1, 4);
        push(4'b0111, S1, 1'b1, 4);
        for (int i = 0; i < 4; i++) push(~(4'b0001 << i), S2, 1'b1, 4);
        push(4'b1110, S2, 1'b0, 4);
        push(4'b1101, S2, 1'b1, 4);
        push(4'b1111, SOFF, 1'b1, 4);
        push(4'b0111, S2, 1'b1, 4);
`ifdef LEADING_ZERO_SUPPRESS_EN
        push(4'b1110, S0, 1'b1, 4);
        push(4'b1101, S3, 1'b1, 4);
        push(4'b1111, SOFF, 1'b1, 8);
`else
        push(4'b1110, S0, 1'b1, 4);
        push(4'b1101, S3, 1'b1, 4);
        push(4'b1011, S0, 1'b1, 4);
        push(4'b0111, S0, 1'b1, 4);
`endif
        push_zero_frame();
        mon_en = 1'b1;

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hi_first_an",  {28'h0, h_an}, 32'h1);
        check("hi_first_seg", {25'h0, hCA, hCB, hCC, hCD, hCE, hCF, hCG}, {25'h0, 7'b1111110});
        check("hi_first_dp",  {31'h0, hDP}, 32'h0);

        do_load(16'h12AF);
        wait_ft();
        repeat (2) @(negedge clk);
        value = 16'h1111;
        load  = 1'b1;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load  = 1'b0;
        wait_ft();
        wait_ft();
        blank = 4'b0100;
        dp_in = 4'b0001;
        repeat (2) @(negedge clk);
        do_load(16'h0030);
        wait_ft();
        blank = 4'b0000;
        dp_in = 4'b0000;
        repeat (2) @(negedge clk);
        do_load(16'h0000);
        wait_ft();
        drain();

        // Reset mid-frame with a load still pending.
        repeat (2) @(negedge clk);
        do_load(16'h9999);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_seg", {25'h0, CA, CB, CC, CD, CE, CF, CG}, {25'h0, SOFF});
        check("midrst_dp",  {31'h0, DP}, 32'h1);
        check("midrst_an",  {28'h0, an}, 32'hF);
        check("midrst_ft",  {31'h0, frame_tick}, 32'h0);
        repeat (2) @(negedge clk);
        push_zero_frame();
        push_zero_frame();
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
